// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with write-back source select and load extraction
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 stall,
  input  logic                                 flush,
  input  logic                                 cnt_clr,
  input  logic                                 in_valid,
  input  logic                                 in_reg_write,
  input  logic [1:0]                           in_wb_sel,
  input  logic [ADDR_W-1:0]                    in_rd,
  input  logic [DATA_W-1:0]                    in_alu_result,
  input  logic [DATA_W-1:0]                    in_mem_rdata,
  input  logic [DATA_W-1:0]                    in_link_addr,
  input  logic [DATA_W-1:0]                    in_imm,
  input  logic [1:0]                           in_ld_size,
  input  logic                                 in_ld_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]          in_byte_off,
  output logic                                 wb_valid,
  output logic                                 wb_reg_write,
  output logic [ADDR_W-1:0]                    wb_rd,
  output logic [DATA_W-1:0]                    wb_data,
  output logic                                 wb_misaligned,
  output logic [CNT_W-1:0]                     retired_cnt
);

  localparam int LANE_W = $clog2(DATA_W/8);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] next_data;
  logic              misaligned;
  logic              next_reg_write;
  logic              capture;

  // Load extraction: bring the addressed lane down to bit 0, then extend to DATA_W.
  // A half load at the top lane of a 64-bit word shifts in zeros for the missing lane;
  // that case is always flagged misaligned so the value is never written back.
  always_comb begin
    shifted = in_mem_rdata >> {in_byte_off, 3'b000};
    ld_data = shifted;
    case (in_ld_size)
      SZ_BYTE: ld_data = {{(DATA_W-8){shifted[7] & ~in_ld_unsigned}}, shifted[7:0]};
      SZ_HALF: ld_data = {{(DATA_W-16){shifted[15] & ~in_ld_unsigned}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Source select, misalignment and register-write qualification for the next capture.
  always_comb begin
    misaligned = 1'b0;
    if (in_wb_sel == SEL_MEM) begin
      if (in_ld_size == SZ_HALF)
        misaligned = in_byte_off[0];
      else if (in_ld_size != SZ_BYTE)
        misaligned = (in_byte_off != '0);
    end
    case (in_wb_sel)
      SEL_ALU:  next_data = in_alu_result;
      SEL_MEM:  next_data = ld_data;
      SEL_LINK: next_data = in_link_addr;
      SEL_IMM:  next_data = in_imm;
      default:  next_data = in_alu_result;
    endcase
    next_reg_write = in_valid & in_reg_write & (in_rd != '0) & ~misaligned;
    capture        = ~flush & ~stall;
  end

  // Pipeline register: flush loads a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_misaligned <= 1'b0;
    end else if (flush) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_misaligned <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= in_valid;
      wb_reg_write  <= next_reg_write;
      wb_rd         <= in_rd;
      wb_data       <= next_data;
      wb_misaligned <= in_valid & misaligned;
    end
  end

  // Retired-instruction counter: clear wins over a same-edge increment; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired_cnt <= '0;
    else if (cnt_clr)
      retired_cnt <= '0;
    else if (capture && in_valid && !misaligned)
      retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, cnt_clr;
  logic        in_valid, in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_mem_rdata, in_link_addr, in_imm;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [1:0]  in_byte_off;
  logic        wb_valid, wb_reg_write, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  retired_cnt;

  int passed = 0;
  int total  = 0;

  wb_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_link_addr(in_link_addr), .in_imm(in_imm), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_byte_off(in_byte_off),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misaligned(wb_misaligned), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] rd,
                       input logic [1:0] sz, input logic uns, input logic [1:0] off);
    in_valid = v; in_reg_write = rw; in_wb_sel = sel; in_rd = rd;
    in_ld_size = sz; in_ld_unsigned = uns; in_byte_off = off;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                         input logic [31:0] d, input logic mis, input logic [3:0] cnt);
    chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, v});
    chk({tag, ".reg_write"}, {31'd0, wb_reg_write}, {31'd0, rw});
    chk({tag, ".rd"}, {27'd0, wb_rd}, {27'd0, rd});
    chk({tag, ".data"}, wb_data, d);
    chk({tag, ".misaligned"}, {31'd0, wb_misaligned}, {31'd0, mis});
    chk({tag, ".cnt"}, {28'd0, retired_cnt}, {28'd0, cnt});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_alu_result = 32'h1111_1111; in_mem_rdata = 32'h80FF_7F01;
    in_link_addr = 32'h0040_0010; in_imm = 32'hDEAD_BEEF;
    drive(1, 1, 2'b00, 5'd9, 2'b10, 0, 2'd0);
    tick(); tick();
    chk_out("reset", 0, 0, 5'd0, 32'h0, 0, 4'd0);
    rst_n = 1'b1;

    // ALU source
    in_alu_result = 32'h1234_5678;
    drive(1, 1, 2'b00, 5'd5, 2'b10, 0, 2'd0);
    tick(); chk_out("alu", 1, 1, 5'd5, 32'h1234_5678, 0, 4'd1);

    // Byte loads from 0x80FF7F01
    drive(1, 1, 2'b01, 5'd6, 2'b00, 0, 2'd2);
    tick(); chk_out("lb_off2", 1, 1, 5'd6, 32'hFFFF_FFFF, 0, 4'd2);
    drive(1, 1, 2'b01, 5'd6, 2'b00, 1, 2'd3);
    tick(); chk_out("lbu_off3", 1, 1, 5'd6, 32'h0000_0080, 0, 4'd3);
    drive(1, 1, 2'b01, 5'd6, 2'b00, 0, 2'd1);
    tick(); chk_out("lb_off1", 1, 1, 5'd6, 32'h0000_007F, 0, 4'd4);

    // Aligned half loads
    drive(1, 1, 2'b01, 5'd8, 2'b01, 0, 2'd0);
    tick(); chk_out("lh_off0", 1, 1, 5'd8, 32'h0000_7F01, 0, 4'd5);
    drive(1, 1, 2'b01, 5'd8, 2'b01, 0, 2'd2);
    tick(); chk_out("lh_off2", 1, 1, 5'd8, 32'hFFFF_80FF, 0, 4'd6);

    // Misaligned half and word: data still extracted, no write, no count
    drive(1, 1, 2'b01, 5'd8, 2'b01, 0, 2'd1);
    tick(); chk_out("lh_mis", 1, 0, 5'd8, 32'hFFFF_FF7F, 1, 4'd6);
    drive(1, 1, 2'b01, 5'd8, 2'b10, 0, 2'd2);
    tick(); chk_out("lw_mis", 1, 0, 5'd8, 32'h0000_80FF, 1, 4'd6);

    // Aligned word (reserved size treated as word)
    drive(1, 1, 2'b01, 5'd4, 2'b11, 1, 2'd0);
    tick(); chk_out("lw_off0", 1, 1, 5'd4, 32'h80FF_7F01, 0, 4'd7);

    // LINK to rd=0: no write, still valid and counted
    drive(1, 1, 2'b10, 5'd0, 2'b00, 0, 2'd0);
    tick(); chk_out("link_rd0", 1, 0, 5'd0, 32'h0040_0010, 0, 4'd8);

    // IMM source
    drive(1, 1, 2'b11, 5'd3, 2'b00, 0, 2'd0);
    tick(); chk_out("imm", 1, 1, 5'd3, 32'hDEAD_BEEF, 0, 4'd9);

    // Invalid misaligned-looking input: data/rd capture, flags stay clear
    drive(0, 1, 2'b01, 5'd12, 2'b01, 0, 2'd1);
    tick(); chk_out("invalid", 0, 0, 5'd12, 32'hFFFF_FF7F, 0, 4'd9);

    // Stall for 3 cycles with changing inputs
    in_alu_result = 32'hAAAA_5555;
    drive(1, 1, 2'b00, 5'd7, 2'b10, 0, 2'd0);
    tick(); chk_out("pre_stall", 1, 1, 5'd7, 32'hAAAA_5555, 0, 4'd10);
    stall = 1'b1;
    in_alu_result = 32'h0101_0101; in_rd = 5'd20;
    tick(); chk_out("stall1", 1, 1, 5'd7, 32'hAAAA_5555, 0, 4'd10);
    in_alu_result = 32'h0202_0202; in_rd = 5'd21; in_wb_sel = 2'b11;
    tick(); chk_out("stall2", 1, 1, 5'd7, 32'hAAAA_5555, 0, 4'd10);
    in_valid = 1'b0; in_rd = 5'd22;
    tick(); chk_out("stall3", 1, 1, 5'd7, 32'hAAAA_5555, 0, 4'd10);

    // Flush together with stall
    in_valid = 1'b1; flush = 1'b1;
    tick(); chk_out("flush_stall", 0, 0, 5'd0, 32'h0, 0, 4'd10);
    stall = 1'b0;

    // Flush alone with a valid input: bubble, no count
    tick(); chk_out("flush", 0, 0, 5'd0, 32'h0, 0, 4'd10);
    flush = 1'b0;

    // Reset asserted mid-stall: outputs clear without a clock edge
    in_alu_result = 32'h5A5A_5A5A;
    drive(1, 1, 2'b00, 5'd9, 2'b10, 0, 2'd0);
    tick(); chk_out("pre_rst", 1, 1, 5'd9, 32'h5A5A_5A5A, 0, 4'd11);
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 5'd0, 32'h0, 0, 4'd0);
    rst_n = 1'b1; stall = 1'b0;

    // Counter wrap with a 4-bit counter
    in_alu_result = 32'h0000_0042;
    drive(1, 1, 2'b00, 5'd1, 2'b10, 0, 2'd0);
    for (int i = 1; i <= 15; i++) tick();
    chk("cnt_15", {28'd0, retired_cnt}, 32'd15);
    tick();
    chk("cnt_wrap", {28'd0, retired_cnt}, 32'd0);

    // Clear beats same-edge increment
    tick(); tick(); tick();
    chk("cnt_3", {28'd0, retired_cnt}, 32'd3);
    cnt_clr = 1'b1;
    tick();
    chk("cnt_clr", {28'd0, retired_cnt}, 32'd0);
    chk("cnt_clr_data", wb_data, 32'h0000_0042);
    cnt_clr = 1'b0;
    tick();
    chk("cnt_after_clr", {28'd0, retired_cnt}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
